// File: rtl/rhd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rhd_pkg
//  Purpose  : Shared opcodes, slot-type and FSM-state types for the RHD
//             convert sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package rhd_pkg;

    localparam logic [1:0]  OP_CONVERT = 2'b00;
    localparam logic [1:0]  OP_READ    = 2'b11;
    localparam logic [5:0]  REG_DUMMY  = 6'd63;
    localparam logic [15:0] CMD_DUMMY  = {OP_READ, REG_DUMMY, 8'h00};

    typedef enum logic [1:0] {
        SLOT_CONVERT = 2'd0,
        SLOT_AUX     = 2'd1,
        SLOT_FLUSH   = 2'd2
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    function automatic logic [15:0] convert_cmd(input logic [5:0] ch);
        return {OP_CONVERT, ch, 8'h00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rhd_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : rhd_tag_pipe
//  Purpose  : Two-deep shift of {slot type, channel} so each MISO word can be
//             matched to the command issued two transfers earlier.
//  Revision : 1.0  initial release
// ============================================================================
module rhd_tag_pipe
    import rhd_pkg::*;
#(
    parameter int CH_W = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_clear,
    input  logic            i_advance,
    input  slot_t           i_type,
    input  logic [CH_W-1:0] i_ch,
    output slot_t           o_type,
    output logic [CH_W-1:0] o_ch
);

    slot_t           r_type0;
    slot_t           r_type1;
    logic [CH_W-1:0] r_ch0;
    logic [CH_W-1:0] r_ch1;

    // Empty entries read as FLUSH so the first two results of a frame drop out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_type0 <= SLOT_FLUSH;
            r_type1 <= SLOT_FLUSH;
            r_ch0   <= '0;
            r_ch1   <= '0;
        end else if (i_clear) begin
            r_type0 <= SLOT_FLUSH;
            r_type1 <= SLOT_FLUSH;
            r_ch0   <= '0;
            r_ch1   <= '0;
        end else if (i_advance) begin
            r_type1 <= r_type0;
            r_ch1   <= r_ch0;
            r_type0 <= i_type;
            r_ch0   <= i_ch;
        end
    end

    assign o_type = r_type1;
    assign o_ch   = r_ch1;

endmodule
`default_nettype wire

// File: rtl/rhd_convert_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rhd_convert_sequencer
//  Purpose  : Issues one frame of CONVERT commands (+ optional aux slot and
//             two flush reads) to rhd_spi_master per sample tick, and tags the
//             pipelined results. Aux slot enabled by macro RHD_SEQ_AUX_EN.
//  Revision : 1.0  initial release
// ============================================================================
module rhd_convert_sequencer
    import rhd_pkg::*;
#(
    parameter int MAX_CH = 32,
    parameter int CH_W   = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic            frame_trig,
    input  logic [CH_W-1:0] num_channels,
    output logic            spi_start,
    output logic [15:0]     spi_data_in,
    input  logic            spi_done,
    input  logic [15:0]     spi_rx,
    output logic            sample_valid,
    output logic [CH_W-1:0] sample_channel,
    output logic [15:0]     sample_data,
    input  logic [15:0]     aux_cmd,
    output logic            aux_valid,
    output logic [15:0]     aux_data,
    output logic            frame_done,
    output logic            overrun
);

    localparam int c_K_W = CH_W + 1;
    localparam logic [c_K_W-1:0] c_MAX_N = c_K_W'(MAX_CH);
`ifdef RHD_SEQ_AUX_EN
    localparam logic [c_K_W-1:0] c_TAIL = c_K_W'(3);
`else
    localparam logic [c_K_W-1:0] c_TAIL = c_K_W'(2);
`endif

    state_t           r_state;
    state_t           w_next_state;
    logic [c_K_W-1:0] r_k;
    logic [c_K_W-1:0] r_n;
    logic [c_K_W-1:0] r_len;
    logic [c_K_W-1:0] w_n_clamped;
    logic [c_K_W-1:0] w_k_next;
    logic [15:0]      r_cmd;
    logic [15:0]      w_aux_cmd_q;
    logic             w_accept;
    logic             w_last;
    logic             w_done_slot;
    slot_t            w_cur_type;
    slot_t            w_next_type;
    slot_t            w_tag_type;
    logic [CH_W-1:0]  w_tag_ch;

    function automatic slot_t slot_of(input logic [c_K_W-1:0] k,
                                      input logic [c_K_W-1:0] n);
        if (k < n) return SLOT_CONVERT;
`ifdef RHD_SEQ_AUX_EN
        if (k == n) return SLOT_AUX;
`endif
        return SLOT_FLUSH;
    endfunction

    function automatic logic [15:0] slot_cmd(input slot_t t,
                                             input logic [c_K_W-1:0] k,
                                             input logic [15:0] aux);
        case (t)
            SLOT_CONVERT: return convert_cmd(k[5:0]);
            SLOT_AUX:     return aux;
            default:      return CMD_DUMMY;
        endcase
    endfunction

    assign w_n_clamped = ({1'b0, num_channels} > c_MAX_N) ? c_MAX_N : {1'b0, num_channels};
    assign w_k_next    = r_k + c_K_W'(1);
    assign w_last      = (w_k_next == r_len);
    assign w_done_slot = (r_state == ST_WAIT) && spi_done;
    assign w_cur_type  = slot_of(r_k, r_n);
    assign w_next_type = slot_of(w_k_next, r_n);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // frame_done and overrun are decoded in the spi_done/trig cycle itself,
    // so a trigger coinciding with frame_done still sees a busy FSM.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        spi_start    = 1'b0;
        frame_done   = 1'b0;
        overrun      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_trig && enable && (num_channels != '0)) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                spi_start    = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (spi_done) begin
                    if (w_last) begin
                        frame_done   = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_START;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (frame_trig && (r_state != ST_IDLE)) begin
            overrun = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_k            <= '0;
            r_n            <= '0;
            r_len          <= '0;
            r_cmd          <= '0;
            sample_valid   <= 1'b0;
            sample_channel <= '0;
            sample_data    <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (w_accept) begin
                r_k   <= '0;
                r_n   <= w_n_clamped;
                r_len <= w_n_clamped + c_TAIL;
                r_cmd <= convert_cmd(6'd0);
            end else if (w_done_slot) begin
                if (w_last) begin
                    r_k <= '0;
                end else begin
                    r_k   <= w_k_next;
                    r_cmd <= slot_cmd(w_next_type, w_k_next, w_aux_cmd_q);
                end
                if (w_tag_type == SLOT_CONVERT) begin
                    sample_valid   <= 1'b1;
                    sample_channel <= w_tag_ch;
                    sample_data    <= spi_rx;
                end
            end
        end
    end

    assign spi_data_in = r_cmd;

    rhd_tag_pipe #(
        .CH_W (CH_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .i_clear   (w_accept),
        .i_advance (w_done_slot),
        .i_type    (w_cur_type),
        .i_ch      (r_k[CH_W-1:0]),
        .o_type    (w_tag_type),
        .o_ch      (w_tag_ch)
    );

`ifdef RHD_SEQ_AUX_EN
    logic [15:0] r_aux_cmd;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_aux_cmd <= '0;
            aux_valid <= 1'b0;
            aux_data  <= '0;
        end else begin
            aux_valid <= 1'b0;
            if (w_accept) begin
                r_aux_cmd <= aux_cmd;
            end
            if (w_done_slot && (w_tag_type == SLOT_AUX)) begin
                aux_valid <= 1'b1;
                aux_data  <= spi_rx;
            end
        end
    end

    assign w_aux_cmd_q = r_aux_cmd;
`else
    logic w_unused_aux;

    assign w_unused_aux = ^aux_cmd;
    assign w_aux_cmd_q  = 16'h0000;
    assign aux_valid    = 1'b0;
    assign aux_data     = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rhd_convert_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rhd_convert_sequencer
//  Purpose  : Scoreboard bench for rhd_convert_sequencer with a behavioural
//             RHD slave returning (command two transfers back) ^ 16'h5A5A.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rhd_convert_sequencer;

    localparam int CH_W = 6;
`ifdef RHD_SEQ_AUX_EN
    localparam int AUX_SLOTS = 1;
`else
    localparam int AUX_SLOTS = 0;
`endif
    localparam logic [15:0] CMD4 [6] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'hFF00, 16'hFF00};
    localparam logic [21:0] SMP4 [4] = '{{6'd0, 16'h5A5A}, {6'd1, 16'h5B5A}, {6'd2, 16'h585A}, {6'd3, 16'h595A}};
    localparam logic [15:0] AUX_CMD = 16'hE800;
    localparam logic [15:0] AUX_RX  = 16'hB25A;

    logic            clk;
    logic            rstn;
    logic            enable;
    logic            frame_trig;
    logic [CH_W-1:0] num_channels;
    logic            spi_start;
    logic [15:0]     spi_data_in;
    logic            spi_done;
    logic [15:0]     spi_rx;
    logic            sample_valid;
    logic [CH_W-1:0] sample_channel;
    logic [15:0]     sample_data;
    logic [15:0]     aux_cmd;
    logic            aux_valid;
    logic [15:0]     aux_data;
    logic            frame_done;
    logic            overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int start_cnt = 0;
    int frame_cnt = 0;
    int ovr_cnt = 0;
    int samp_cnt = 0;
    int aux_cnt = 0;

    logic [15:0] q_cmd [$];
    logic [21:0] q_samp [$];
    logic [15:0] q_aux [$];

    rhd_convert_sequencer dut (
        .clk            (clk),
        .rstn           (rstn),
        .enable         (enable),
        .frame_trig     (frame_trig),
        .num_channels   (num_channels),
        .spi_start      (spi_start),
        .spi_data_in    (spi_data_in),
        .spi_done       (spi_done),
        .spi_rx         (spi_rx),
        .sample_valid   (sample_valid),
        .sample_channel (sample_channel),
        .sample_data    (sample_data),
        .aux_cmd        (aux_cmd),
        .aux_valid      (aux_valid),
        .aux_data       (aux_data),
        .frame_done     (frame_done),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave: result of each transfer is derived from the command two transfers back.
    initial begin : slave
        logic [15:0] c;
        logic [15:0] h1;
        logic [15:0] h2;
        h1 = '0;
        h2 = '0;
        spi_done = 1'b0;
        spi_rx   = '0;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (rstn && spi_start) begin
                c = spi_data_in;
                repeat (3) @(negedge clk);
                spi_rx   = h2 ^ 16'h5A5A;
                h2       = h1;
                h1       = c;
                spi_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [21:0] e;
        #2;
        cyc++;
        if (rstn) begin
            if (spi_start) begin
                start_cnt++;
                if (q_cmd.size() == 0) check("unexpected_spi_start_q_depth", q_cmd.size(), 1);
                else check("spi_data_in", spi_data_in, q_cmd.pop_front());
            end
            if (sample_valid) begin
                samp_cnt++;
                check("sample_latency", cyc - last_done_cyc, 1);
                if (q_samp.size() == 0) check("unexpected_sample_q_depth", q_samp.size(), 1);
                else begin
                    e = q_samp.pop_front();
                    check("sample_channel", sample_channel, e[21:16]);
                    check("sample_data", sample_data, e[15:0]);
                end
            end
            if (aux_valid) begin
                aux_cnt++;
                if (q_aux.size() == 0) check("unexpected_aux_q_depth", q_aux.size(), 1);
                else check("aux_data", aux_data, q_aux.pop_front());
            end
            if (spi_done) last_done_cyc = cyc;
            if (frame_done) frame_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    task automatic reset_counts();
        start_cnt = 0;
        frame_cnt = 0;
        ovr_cnt   = 0;
        samp_cnt  = 0;
        aux_cnt   = 0;
    endtask

    task automatic pulse_trig();
        @(negedge clk);
        #1 frame_trig = 1'b1;
        @(negedge clk);
        #1 frame_trig = 1'b0;
    endtask

    task automatic expect_n4();
        for (int i = 0; i < 4; i++) q_cmd.push_back(CMD4[i]);
        if (AUX_SLOTS == 1) begin
            q_cmd.push_back(AUX_CMD);
            q_aux.push_back(AUX_RX);
        end
        q_cmd.push_back(CMD4[4]);
        q_cmd.push_back(CMD4[5]);
        for (int i = 0; i < 4; i++) q_samp.push_back(SMP4[i]);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int i;
        i = 0;
        while (frame_cnt < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("frame_done_count", frame_cnt, target);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int i;
        i = 0;
        while (start_cnt < target && i < budget) begin
            @(negedge clk);
            #3;
            i++;
        end
        check("start_wait", (start_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic check_queues_empty();
        check("cmd_queue_left", q_cmd.size(), 0);
        check("sample_queue_left", q_samp.size(), 0);
        check("aux_queue_left", q_aux.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spi_start"}, spi_start, 0);
        check({tag, "_spi_data_in"}, spi_data_in, 0);
        check({tag, "_sample_valid"}, sample_valid, 0);
        check({tag, "_sample_channel"}, sample_channel, 0);
        check({tag, "_sample_data"}, sample_data, 0);
        check({tag, "_aux_valid"}, aux_valid, 0);
        check({tag, "_aux_data"}, aux_data, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] c;
        bit found;
        rstn         = 1'b0;
        enable       = 1'b0;
        frame_trig   = 1'b0;
        num_channels = '0;
        aux_cmd      = AUX_CMD;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("rst");
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Basic N=4 frame
        reset_counts();
        enable = 1'b1;
        num_channels = 6'd4;
        expect_n4();
        pulse_trig();
        wait_frames(1, 300);
        check("n4_starts", start_cnt, 6 + AUX_SLOTS);
        check("n4_samples", samp_cnt, 4);
        check("n4_aux", aux_cnt, AUX_SLOTS);
        check("n4_overrun", ovr_cnt, 0);
        check_queues_empty();

        // Trigger mid-frame
        reset_counts();
        expect_n4();
        pulse_trig();
        wait_starts(3, 100);
        pulse_trig();
        wait_frames(1, 300);
        check("mid_overrun", ovr_cnt, 1);
        check("mid_starts", start_cnt, 6 + AUX_SLOTS);
        check("mid_samples", samp_cnt, 4);
        check_queues_empty();

        // Trigger in the frame_done cycle
        reset_counts();
        expect_n4();
        pulse_trig();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            #1;
            if (frame_done) found = 1'b1;
        end
        check("coincident_seen_frame_done", found, 1);
        frame_trig = 1'b1;
        @(negedge clk);
        #1 frame_trig = 1'b0;
        repeat (40) @(negedge clk);
        check("coincident_overrun", ovr_cnt, 1);
        check("coincident_starts", start_cnt, 6 + AUX_SLOTS);
        check("coincident_frames", frame_cnt, 1);
        check_queues_empty();

        // Clamp 40 -> 32
        reset_counts();
        num_channels = 6'd40;
        for (int k = 0; k < 32; k++) begin
            c = {2'b00, 6'(k), 8'h00};
            q_cmd.push_back(c);
            q_samp.push_back({6'(k), c ^ 16'h5A5A});
        end
        if (AUX_SLOTS == 1) begin
            q_cmd.push_back(AUX_CMD);
            q_aux.push_back(AUX_RX);
        end
        q_cmd.push_back(16'hFF00);
        q_cmd.push_back(16'hFF00);
        pulse_trig();
        wait_frames(1, 2000);
        check("clamp_starts", start_cnt, 34 + AUX_SLOTS);
        check("clamp_samples", samp_cnt, 32);
        check_queues_empty();

        // Ignored triggers
        reset_counts();
        num_channels = 6'd0;
        pulse_trig();
        repeat (30) @(negedge clk);
        check("zero_ch_starts", start_cnt, 0);
        check("zero_ch_overrun", ovr_cnt, 0);
        enable = 1'b0;
        num_channels = 6'd4;
        pulse_trig();
        repeat (30) @(negedge clk);
        check("disabled_starts", start_cnt, 0);
        check("disabled_overrun", ovr_cnt, 0);

        // Enable drop and num_channels change mid-frame
        reset_counts();
        enable = 1'b1;
        expect_n4();
        pulse_trig();
        wait_starts(2, 100);
        enable = 1'b0;
        num_channels = 6'd9;
        wait_frames(1, 300);
        check("en_drop_starts", start_cnt, 6 + AUX_SLOTS);
        check("en_drop_samples", samp_cnt, 4);
        check_queues_empty();
        pulse_trig();
        repeat (30) @(negedge clk);
        check("en_drop_no_new_frame", start_cnt, 6 + AUX_SLOTS);

        // Reset during slot 2
        reset_counts();
        enable = 1'b1;
        num_channels = 6'd4;
        expect_n4();
        pulse_trig();
        wait_starts(3, 100);
        rstn = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (10) @(negedge clk);
        q_cmd.delete();
        q_samp.delete();
        q_aux.delete();
        #1 rstn = 1'b1;
        repeat (10) @(negedge clk);
        reset_counts();
        expect_n4();
        pulse_trig();
        wait_frames(1, 300);
        check("post_rst_starts", start_cnt, 6 + AUX_SLOTS);
        check("post_rst_samples", samp_cnt, 4);
        check_queues_empty();

`ifdef RHD_SEQ_AUX_EN
        // Aux slot with N=2
        reset_counts();
        num_channels = 6'd2;
        q_cmd.push_back(16'h0000);
        q_cmd.push_back(16'h0100);
        q_cmd.push_back(16'hE800);
        q_cmd.push_back(16'hFF00);
        q_cmd.push_back(16'hFF00);
        q_samp.push_back({6'd0, 16'h5A5A});
        q_samp.push_back({6'd1, 16'h5B5A});
        q_aux.push_back(16'hB25A);
        pulse_trig();
        wait_frames(1, 300);
        check("aux2_starts", start_cnt, 5);
        check("aux2_aux_count", aux_cnt, 1);
        check_queues_empty();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rhd_convert_sequencer.md
RHD_CONVERT_SEQUENCER -- requirements
Module: rhd_convert_sequencer

Interface
REQ-001 Parameter MAX_CH, default 32: maximum CONVERT slots per frame.
REQ-002 Parameter CH_W, default 6: channel field width, matching the RHD command channel field.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  permits new frames; sampled only in IDLE.
REQ-006 frame_trig  input  1  one-cycle sample-rate tick requesting a frame.
REQ-007 num_channels  input  CH_W  CONVERT slots per frame, latched at frame start.
REQ-008 spi_start  output  1  one-cycle start pulse to rhd_spi_master.
REQ-009 spi_data_in  output  16  command word to rhd_spi_master; held stable from spi_start until spi_done.
REQ-010 spi_done  input  1  one-cycle pulse, transfer complete, spi_rx valid.
REQ-011 spi_rx  input  16  MISO word captured in the completed transfer.
REQ-012 sample_valid, sample_channel[CH_W], sample_data[16]  outputs: one conversion result with its channel tag.
REQ-013 aux_cmd  input  16; aux_valid  output  1; aux_data  output  16: auxiliary slot (see Configuration).
REQ-014 frame_done  output  1: one-cycle pulse after the last slot's spi_done; overrun  output  1: one-cycle pulse.

Function
REQ-015 FSM states IDLE, START, WAIT; reset state IDLE.
REQ-016 IDLE->START when frame_trig & enable & num_channels!=0; latch min(num_channels, MAX_CH) as N; slot index k=0.
REQ-017 START: spi_start=1 for exactly one cycle, spi_data_in = command for slot k; next state WAIT.
REQ-018 WAIT: on spi_done, k increments; if k+1 < frame length -> START next cycle, else -> IDLE with frame_done pulse that cycle.
REQ-019 Slot commands: k<N -> CONVERT {2'b00, k[5:0], 8'h00}; trailing two flush slots -> dummy READ reg 63 {2'b11, 6'd63, 8'h00}.
REQ-020 Frame length N+2 (N+3 with aux); flush slots are always the final two.
REQ-021 RHD 2-command pipeline: spi_rx at slot k's spi_done belongs to slot k-2; k<2 results are discarded.
REQ-022 On spi_done at k>=2: if slot k-2 is CONVERT -> sample_valid=1 one cycle, sample_channel=k-2, sample_data=spi_rx, registered (1-cycle latency after spi_done).
REQ-023 Results of flush slots never produce sample_valid or aux_valid.
REQ-024 frame_trig while not IDLE -> ignored, overrun pulses one cycle; frame in progress unaffected.
REQ-025 frame_trig in IDLE with enable=0 or num_channels=0 -> ignored, no overrun.
REQ-026 enable deassert mid-frame -> frame completes normally; no new frame accepted.
REQ-027 num_channels > MAX_CH -> clamped to MAX_CH; changes mid-frame have no effect.
REQ-028 frame_trig coincident with frame_done cycle -> treated as overrun (FSM not yet IDLE).

Reset
REQ-029 rstn low: state IDLE, k=0, spi_start=0, spi_data_in=16'h0000, sample_valid=0, sample_channel=0, sample_data=0, aux_valid=0, aux_data=0, frame_done=0, overrun=0.
REQ-030 Reset mid-frame aborts immediately; no partial-frame outputs after release; first frame after release starts at k=0.

Configuration
REQ-031 Macro RHD_SEQ_AUX_EN defined: one aux slot inserted at k=N (after CONVERTs, before flush), command = aux_cmd latched at frame start; its result drives aux_valid/aux_data with the REQ-022 latency.
REQ-032 RHD_SEQ_AUX_EN undefined: no aux slot, frame length N+2, aux_cmd ignored, aux_valid and aux_data held 0; ports remain present.

Structure
REQ-033 Shared package rhd_pkg: CONVERT/dummy opcode constants, REG_DUMMY=63, slot-type enum (CONVERT, AUX, FLUSH), FSM state enum.
REQ-034 Sub-module rhd_tag_pipe: 2-deep shift of {slot-type, channel} advanced on spi_done, cleared at frame start and reset.

Verification
REQ-035 N=4, trig -> 6 spi_start pulses, commands 0x0000,0x0100,0x0200,0x0300,0xFF00,0xFF00; one frame_done.
REQ-036 N=4, slave returns channel-tagged data -> sample_valid x4, channels 0,1,2,3 in order, each on the transfer two slots later.
REQ-037 frame_trig mid-frame -> overrun pulse, spi_start count still 6, sample sequence unchanged.
REQ-038 num_channels=40 -> N clamped to 32, 34 transfers; num_channels=0 or enable=0 -> no spi_start.
REQ-039 rstn low during slot 2 -> all outputs reset values within same cycle; next trig yields a clean frame from k=0.
REQ-040 With RHD_SEQ_AUX_EN, N=2, aux_cmd=0xE800 -> commands 0x0000,0x0100,0xE800,0xFF00,0xFF00; one aux_valid carrying last-slot-minus-two rx.
